dm_sized_mem: RTL and testbench
===============================

// Module: dm_sized_mem
// PURPOSE
//  Parametrised data memory for the MEM stage. Handles byte/half/word loads and stores
//  with byte-lane writes and sign/zero extension on loads. Read latency is selectable.
//  Misaligned accesses are detected and never reach the array.
//  A clear sequencer zeroes the array one word per cycle after reset or on request.
// PARAMETERS
//  DEPTH     1024  number of 32-bit words; power of two, >= 4
//  AW        10    word-index width = log2(DEPTH)
//  READ_LAT  1     load latency in cycles: 0 (combinational rdata) or 1 (registered rdata)
//  TRACE     1     1 = $display each committed store as "%d@%h: *%h <= %h" (time, pc, addr, merged word)
// PORTS
//  clk        in   1   clock, rising edge
//  clr_n      in   1   reset, synchronous, active-low
//  req        in   1   access request, sampled only when ready=1
//  we         in   1   1 = store, 0 = load
//  size       in   2   00 byte, 01 half, 10 word; 11 is treated as word
//  sign_ext   in   1   loads only: 1 = sign-extend, 0 = zero-extend
//  addr       in   32  byte address; index = addr[AW+1:2], upper bits ignored (wrap)
//  wd         in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  pc         in   32  PC of the requesting instruction, used only by the trace
//  clr_req    in   1   soft clear request, honoured only in IDLE
//  rdata      out  32  load result, extended to 32 bits
//  rvalid     out  1   rdata valid; pulses once per accepted aligned or misaligned load
//  misalign   out  1   one-cycle pulse when an accepted access is misaligned
//  busy       out  1   clear sweep in progress
//  ready      out  1   = ~busy; requests are accepted only when ready=1
// BEHAVIOUR
//  Reset (clr_n=0 at a rising edge): rdata=0, rvalid=0, misalign=0, busy=1, ready=0.
//   Sweep counter is forced to 0 and the FSM is forced to CLEAR, including mid-sweep or mid-access.
//  FSM states:
//   CLEAR: each cycle with clr_n=1, writes mem[cnt]=0 and increments cnt.
//    After the write of index DEPTH-1, moves to IDLE; busy falls on that same edge.
//    The sweep therefore takes exactly DEPTH cycles after reset is released.
//    req and clr_req are ignored; no rvalid, misalign or trace output.
//   IDLE: clr_req=1 -> CLEAR with cnt=0; any req in that cycle is dropped.
//    Otherwise a req=1 is accepted.
//  Alignment rules:
//   Half is misaligned if addr[0]=1. Word (or size=11) is misaligned if addr[1:0]!=0.
//   Byte is never misaligned.
//  Aligned store: only the addressed lanes are written.
//   Byte writes lane addr[1:0] with wd[7:0].
//   Half writes lanes {addr[1],0} and {addr[1],1} with wd[15:0].
//   Word writes all four lanes. Lane 0 = bits [7:0], little-endian.
//   The store is visible to a load accepted on the next cycle. A store never raises rvalid.
//  Aligned load: the addressed byte or half is extracted and extended per sign_ext.
//   Words are returned unchanged.
//   READ_LAT=0: rdata and rvalid are combinational in the request cycle.
//   READ_LAT=1: rdata and rvalid are registered and appear on the cycle after acceptance.
//   Back-to-back loads give one result per cycle.
//  Misaligned access: the array is not modified and no trace is printed.
//   misalign pulses with the same latency as rvalid.
//   A misaligned load also pulses rvalid with rdata=0.
//  When no load result is valid, rdata holds its last value (READ_LAT=1) or shows the current
//   read word (READ_LAT=0); consumers use rdata only when rvalid=1.
//  One access per cycle (single port). No internal queue; the caller must stall while ready=0.
// TESTING
//  Reset, DEPTH=16: clr_n low for 2 cycles, then high -> busy=1 for exactly 16 cycles;
//   then ready=1 and a load of addr 0x3C returns 0.
//  Word store 0xDEADBEEF to 0x8, then byte loads 0x8..0xB with sign_ext=1
//   -> 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFAD, 0xFFFFFFDE; with sign_ext=0 -> 0x000000EF etc.
//  Byte store 0x12 to 0xA over 0xDEADBEEF -> word load of 0x8 returns 0xDE12BEEF.
//   Half store 0x7788 to 0x8 -> 0xDE127788.
//  Half store to 0x5 and word load from 0x6 -> misalign pulse, array unchanged;
//   the load gives rvalid=1 with rdata=0. Check with READ_LAT=0 and READ_LAT=1.
//  Soft clear: clr_req in IDLE, then a req held high during the sweep
//   -> no writes and no rvalid until busy falls; afterwards all words read 0.
//   Asserting clr_n low mid-sweep restarts the sweep from index 0.
//  Wrap: DEPTH=16, store 0x55 to byte address 0x40 -> word load of 0x0 returns 0x00000055.

Source files
------------

// File: rtl/dm_sized_mem.sv
// MEM-stage data memory: byte/half/word loads and stores with lane merge and load extension.
// A clear sequencer zeroes the array one word per cycle after reset or on a soft clear request.
module dm_sized_mem #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned AW       = 10,
  parameter int unsigned READ_LAT = 1,
  parameter bit          TRACE    = 1'b1
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic [31:0] pc,
  input  logic        clr_req,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        misalign,
  output logic        busy,
  output logic        ready
);

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic [31:0]   rword;
  logic          acc;
  logic          mis;
  logic          ld;
  logic          st_ok;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   merged;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic [31:0]   ext;
  logic [31:0]   ld_data;

  // ---------------------------------------------------------------------------
  // Clear sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    busy  = (state_q == StClear);
    ready = ~busy;
  end

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  assign idx   = addr[AW+1:2];
  assign rword = mem[idx];

  // A clear request in IDLE takes priority and drops the coincident access.
  assign acc   = clr_n && ready && req && !clr_req;

  always_comb begin
    mis = 1'b0;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = addr[0];
      default: mis = (addr[1:0] != 2'b00);
    endcase
  end

  assign ld    = acc && !we;
  assign st_ok = acc && we && !mis;

  // ---------------------------------------------------------------------------
  // Store lane merge
  // ---------------------------------------------------------------------------
  always_comb begin
    be    = 4'b1111;
    wlane = wd;
    case (size)
      2'b00: begin
        be    = 4'b0001 << addr[1:0];
        wlane = {4{wd[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wd[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wd;
      end
    endcase
  end

  always_comb begin
    merged = rword;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        merged[8*b +: 8] = wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_n) begin
      if (busy) begin
        mem[cnt_q] <= '0;
      end else if (st_ok) begin
        mem[idx] <= merged;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    bsel = rword[{addr[1:0], 3'b000} +: 8];
    hsel = addr[1] ? rword[31:16] : rword[15:0];
    ext  = rword;
    case (size)
      2'b00:   ext = {{24{sign_ext & bsel[7]}}, bsel};
      2'b01:   ext = {{16{sign_ext & hsel[15]}}, hsel};
      default: ext = rword;
    endcase
  end

  assign ld_data = mis ? 32'h0 : ext;

  generate
    if (READ_LAT == 0) begin : g_lat0
      assign rvalid   = ld;
      assign misalign = acc && mis;
      assign rdata    = ld ? ld_data : rword;
    end else begin : g_lat1
      logic [31:0] rdata_q;
      logic        rvalid_q;
      logic        mis_q;

      always_ff @(posedge clk) begin
        if (!clr_n) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
          mis_q    <= 1'b0;
        end else begin
          rvalid_q <= ld;
          mis_q    <= acc && mis;
          if (ld) begin
            rdata_q <= ld_data;
          end
        end
      end

      assign rvalid   = rvalid_q;
      assign misalign = mis_q;
      assign rdata    = rdata_q;
    end
  endgenerate

  // Simulation-only commit trace; ignored by synthesis.
  generate
    if (TRACE) begin : g_trace
      always_ff @(posedge clk) begin
        if (clr_n && st_ok) begin
          $display("%d@%h: *%h <= %h", $time, pc, addr, merged);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_dm_sized_mem.sv
// Scoreboard bench for dm_sized_mem: two DEPTH=16 instances (READ_LAT=1 and 0) share stimulus;
// expected load/misalign responses are queued at issue and popped by a negedge monitor.
module tb_dm_sized_mem;

  logic        clk = 1'b0;
  logic        clr_n, req, we, sign_ext, clr_req;
  logic [1:0]  size;
  logic [31:0] addr, wd, pc;

  logic [31:0] r1_rdata, r0_rdata;
  logic        r1_rvalid, r1_mis, r1_busy, r1_ready;
  logic        r0_rvalid, r0_mis, r0_busy, r0_ready;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        rv;
    logic        mis;
    logic [31:0] rd;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  exp_t e1, e0;

  always #5 clk = ~clk;

  dm_sized_mem #(.DEPTH(16), .AW(4), .READ_LAT(1), .TRACE(1'b1)) u_l1 (
    .clk(clk), .clr_n(clr_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wd(wd), .pc(pc), .clr_req(clr_req),
    .rdata(r1_rdata), .rvalid(r1_rvalid), .misalign(r1_mis), .busy(r1_busy), .ready(r1_ready)
  );

  dm_sized_mem #(.DEPTH(16), .AW(4), .READ_LAT(0), .TRACE(1'b0)) u_l0 (
    .clk(clk), .clr_n(clr_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wd(wd), .pc(pc), .clr_req(clr_req),
    .rdata(r0_rdata), .rvalid(r0_rvalid), .misalign(r0_mis), .busy(r0_busy), .ready(r0_ready)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: every rvalid or misalign pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (r1_rvalid || r1_mis) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL lat1_unexpected rvalid=%b misalign=%b rdata=%h want=no_output",
                 r1_rvalid, r1_mis, r1_rdata);
      end else begin
        e1 = q1.pop_front();
        check("lat1_rvalid", 32'(r1_rvalid), 32'(e1.rv));
        check("lat1_misalign", 32'(r1_mis), 32'(e1.mis));
        if (e1.rv) check("lat1_rdata", r1_rdata, e1.rd);
      end
    end
    if (r0_rvalid || r0_mis) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL lat0_unexpected rvalid=%b misalign=%b rdata=%h want=no_output",
                 r0_rvalid, r0_mis, r0_rdata);
      end else begin
        e0 = q0.pop_front();
        check("lat0_rvalid", 32'(r0_rvalid), 32'(e0.rv));
        check("lat0_misalign", 32'(r0_mis), 32'(e0.mis));
        if (e0.rv) check("lat0_rdata", r0_rdata, e0.rd);
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                       input logic [31:0] d, input logic m, input logic [31:0] exp_rd);
    exp_t e;
    @(posedge clk);
    #1;
    req      = 1'b1;
    we       = w;
    size     = sz;
    sign_ext = sx;
    addr     = a;
    wd       = d;
    pc       = pc + 32'd4;
    if (!w || m) begin
      e.rv  = !w;
      e.mis = m;
      e.rd  = exp_rd;
      q1.push_back(e);
      q0.push_back(e);
    end
  endtask

  task automatic ld(input logic [1:0] sz, input logic sx, input logic [31:0] a, input logic m,
                    input logic [31:0] exp_rd);
    issue(1'b0, sz, sx, a, 32'h0, m, exp_rd);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                    input logic m);
    issue(1'b1, sz, 1'b0, a, d, m, 32'h0);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  // Counts cycles with busy high, starting in the current cycle; bounded.
  task automatic count_busy(input string name, input int want);
    int n1 = 0;
    int n0 = 0;
    for (int i = 0; i < 100; i++) begin
      if (r1_busy) n1++;
      if (r0_busy) n0++;
      if (!r1_busy && !r0_busy) break;
      @(posedge clk);
      #1;
    end
    check({name, "_lat1"}, 32'(n1), 32'(want));
    check({name, "_lat0"}, 32'(n0), 32'(want));
  endtask

  initial begin
    clr_n    = 1'b0;
    req      = 1'b0;
    we       = 1'b0;
    size     = 2'b10;
    sign_ext = 1'b0;
    addr     = '0;
    wd       = '0;
    pc       = 32'h1000;
    clr_req  = 1'b0;

    // Reset held for two edges
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_busy_l1", 32'(r1_busy), 32'd1);
    check("rst_ready_l1", 32'(r1_ready), 32'd0);
    check("rst_rvalid_l1", 32'(r1_rvalid), 32'd0);
    check("rst_misalign_l1", 32'(r1_mis), 32'd0);
    check("rst_rdata_l1", r1_rdata, 32'h0);
    check("rst_busy_l0", 32'(r0_busy), 32'd1);
    check("rst_ready_l0", 32'(r0_ready), 32'd0);
    check("rst_rvalid_l0", 32'(r0_rvalid), 32'd0);
    clr_n = 1'b1;
    count_busy("sweep_after_reset", 16);
    check("ready_after_sweep", 32'(r1_ready), 32'd1);

    ld(2'b10, 1'b0, 32'h3C, 1'b0, 32'h0);

    // Word store then byte loads with both extensions
    st(2'b10, 32'h8, 32'hDEADBEEF, 1'b0);
    ld(2'b00, 1'b1, 32'h8, 1'b0, 32'hFFFFFFEF);
    ld(2'b00, 1'b1, 32'h9, 1'b0, 32'hFFFFFFBE);
    ld(2'b00, 1'b1, 32'hA, 1'b0, 32'hFFFFFFAD);
    ld(2'b00, 1'b1, 32'hB, 1'b0, 32'hFFFFFFDE);
    ld(2'b00, 1'b0, 32'h8, 1'b0, 32'h000000EF);
    ld(2'b00, 1'b0, 32'h9, 1'b0, 32'h000000BE);
    ld(2'b00, 1'b0, 32'hA, 1'b0, 32'h000000AD);
    ld(2'b00, 1'b0, 32'hB, 1'b0, 32'h000000DE);

    // Lane merge
    st(2'b00, 32'hA, 32'h00000012, 1'b0);
    ld(2'b10, 1'b0, 32'h8, 1'b0, 32'hDE12BEEF);
    st(2'b01, 32'h8, 32'h00007788, 1'b0);
    ld(2'b10, 1'b0, 32'h8, 1'b0, 32'hDE127788);
    ld(2'b01, 1'b1, 32'hA, 1'b0, 32'hFFFFDE12);
    ld(2'b01, 1'b0, 32'hA, 1'b0, 32'h0000DE12);
    ld(2'b01, 1'b1, 32'h8, 1'b0, 32'h00007788);
    ld(2'b00, 1'b1, 32'h9, 1'b0, 32'h00000077);

    // Misaligned accesses leave the array untouched
    st(2'b10, 32'h4, 32'h11223344, 1'b0);
    st(2'b01, 32'h5, 32'h0000AAAA, 1'b1);
    ld(2'b10, 1'b0, 32'h6, 1'b1, 32'h0);
    ld(2'b10, 1'b0, 32'h4, 1'b0, 32'h11223344);
    ld(2'b11, 1'b0, 32'h4, 1'b0, 32'h11223344);
    ld(2'b11, 1'b0, 32'h2, 1'b1, 32'h0);
    ld(2'b01, 1'b1, 32'h7, 1'b1, 32'h0);
    ld(2'b00, 1'b0, 32'h5, 1'b0, 32'h00000033);
    st(2'b11, 32'h9, 32'hFFFFFFFF, 1'b1);
    ld(2'b10, 1'b0, 32'h8, 1'b0, 32'hDE127788);

    // Address wrap
    st(2'b00, 32'h40, 32'h00000055, 1'b0);
    ld(2'b10, 1'b0, 32'h0, 1'b0, 32'h00000055);
    idle();

    // Soft clear: coincident load is dropped, a store held through the sweep never lands
    @(posedge clk);
    #1;
    clr_req  = 1'b1;
    req      = 1'b1;
    we       = 1'b0;
    size     = 2'b10;
    addr     = 32'h8;
    @(posedge clk);
    #1;
    clr_req  = 1'b0;
    we       = 1'b1;
    wd       = 32'hFFFFFFFF;
    count_busy("soft_clear", 16);
    req      = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ld(2'b10, 1'b0, 32'(i * 4), 1'b0, 32'h0);
    end
    idle();

    // Reset mid-sweep restarts from index 0
    @(posedge clk);
    #1;
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    count_busy("sweep_restart", 16);

    st(2'b10, 32'hC, 32'hCAFEF00D, 1'b0);
    ld(2'b10, 1'b0, 32'hC, 1'b0, 32'hCAFEF00D);
    ld(2'b01, 1'b1, 32'hE, 1'b0, 32'hFFFFCAFE);
    idle();

    repeat (3) @(posedge clk);
    #1;
    check("drain_lat1", 32'(q1.size()), 32'd0);
    check("drain_lat0", 32'(q0.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
